// File: rtl/fft_din_fifo.sv
// fft_din_fifo: DEPTH-frame buffer from usb_interface to the FFT core; optional counters via FFT_DIN_FIFO_STATS_EN.
// Latency: a push sampled at edge t is issued (out_valid) after edge t+1; issues are >= 3 cycles apart.
// Backpressure: in_busy while full (further frames dropped, overflow sticky); out_busy stalls issue from IDLE.
module fft_din_fifo #(
  parameter int NPOINT = 3,
  parameter int DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_busy,
  input  logic [16*(2**NPOINT)-1:0]     in_real,
  input  logic [16*(2**NPOINT)-1:0]     in_imag,
  output logic                          out_valid,
  input  logic                          out_busy,
  output logic [16*(2**NPOINT)-1:0]     out_real,
  output logic [16*(2**NPOINT)-1:0]     out_imag,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          overflow
`ifdef FFT_DIN_FIFO_STATS_EN
  ,
  output logic [15:0]                   in_frames,
  output logic [7:0]                    drop_frames
`endif
);

  localparam int W  = 16 << NPOINT;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t        state, state_nxt;
  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, drop, pop;

  assign in_busy = (level == FULL);
  assign push    = in_valid && !in_busy;
  assign drop    = in_valid && in_busy;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (level != '0 && !out_busy) begin
          state_nxt = ISSUE;
          pop       = 1'b1;
        end
      end
      ISSUE: begin
        out_valid = 1'b1;
        state_nxt = HOLD;
      end
      // Guard cycle so the core's out_busy has time to rise.
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_real, in_imag};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      out_real <= '0;
      out_imag <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      // Head is registered and counted out on the IDLE->ISSUE edge.
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        out_real <= mem[rd_ptr].re;
        out_imag <= mem[rd_ptr].im;
      end
      if (push && !pop)      level <= level + (AW+1)'(1);
      else if (pop && !push) level <= level - (AW+1)'(1);
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef FFT_DIN_FIFO_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      in_frames   <= '0;
      drop_frames <= '0;
    end else begin
      if (push) in_frames <= in_frames + 16'd1;
      if (drop && drop_frames != 8'hff) drop_frames <= drop_frames + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_din_fifo.sv
// Directed bench for fft_din_fifo (NPOINT=3, DEPTH=4) with hand-computed expectations.
module tb_fft_din_fifo;
  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_busy;
  logic [127:0] in_real;
  logic [127:0] in_imag;
  logic         out_valid;
  logic         out_busy;
  logic [127:0] out_real;
  logic [127:0] out_imag;
  logic [2:0]   level;
  logic         overflow;
`ifdef FFT_DIN_FIFO_STATS_EN
  logic [15:0]  in_frames;
  logic [7:0]   drop_frames;
`endif

  fft_din_fifo #(.NPOINT(3), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_busy(in_busy), .in_real(in_real), .in_imag(in_imag),
    .out_valid(out_valid), .out_busy(out_busy), .out_real(out_real), .out_imag(out_imag),
    .level(level), .overflow(overflow)
`ifdef FFT_DIN_FIFO_STATS_EN
    , .in_frames(in_frames), .drop_frames(drop_frames)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_err = 0;
  bit           mon_en = 1'b0;
  int           max_lvl = 0;
  logic [127:0] got_q[$];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; observe 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (out_valid) got_q.push_back(out_real);
      if (int'(level) > max_lvl) max_lvl = int'(level);
    end
  endtask

  task automatic push(input logic [127:0] re, input logic [127:0] im);
    in_valid = 1'b1;
    in_real  = re;
    in_imag  = im;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  localparam logic [127:0] SR = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [127:0] SI = 128'hfedcba9876543210fedcba9876543210;

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_real = '0; in_imag = '0; out_busy = 1'b0;
    tick();

    // Reset state
    do_reset();
    check_val("rst_level", 128'(level), 128'd0);
    check_val("rst_in_busy", 128'(in_busy), 128'd0);
    check_val("rst_out_valid", 128'(out_valid), 128'd0);
    check_val("rst_overflow", 128'(overflow), 128'd0);
    check_val("rst_out_real", out_real, 128'd0);

    // Single frame: issue one cycle after push
    push(SR, SI);
    check_val("single_level1", 128'(level), 128'd1);
    check_val("single_nov_early", 128'(out_valid), 128'd0);
    tick();
    check_val("single_valid", 128'(out_valid), 128'd1);
    check_val("single_real", out_real, SR);
    check_val("single_imag", out_imag, SI);
    check_val("single_level0", 128'(level), 128'd0);
    tick();
    check_val("single_pulse_end", 128'(out_valid), 128'd0);
    tick();

    // Fill and overflow with the core busy
    out_busy = 1'b1;
    for (int k = 1; k <= 4; k++) push(128'(k), 128'(k + 100));
    check_val("fill_level4", 128'(level), 128'd4);
    check_val("fill_in_busy", 128'(in_busy), 128'd1);
    check_val("fill_no_ovf", 128'(overflow), 128'd0);
    push(128'd5, 128'd105);
    check_val("ovf_set", 128'(overflow), 128'd1);
    check_val("ovf_level", 128'(level), 128'd4);
`ifdef FFT_DIN_FIFO_STATS_EN
    check_val("ovf_drop_frames", 128'(drop_frames), 128'd1);
    check_val("ovf_in_frames", 128'(in_frames), 128'd5);
`endif
    out_busy = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_val($sformatf("drain_valid%0d", k), 128'(out_valid), 128'd1);
      check_val($sformatf("drain_real%0d", k), out_real, 128'(k));
      check_val($sformatf("drain_imag%0d", k), out_imag, 128'(k + 100));
      if (k == 1) check_val("drain_in_busy_fall", 128'(in_busy), 128'd0);
      tick();
      check_val($sformatf("drain_gap_a%0d", k), 128'(out_valid), 128'd0);
      tick();
      check_val($sformatf("drain_gap_b%0d", k), 128'(out_valid), 128'd0);
    end
    check_val("drain_level0", 128'(level), 128'd0);
    check_val("drain_ovf_sticky", 128'(overflow), 128'd1);
    do_reset();
    check_val("ovf_cleared", 128'(overflow), 128'd0);

    // Backpressure for 20 cycles with 2 frames stored
    out_busy = 1'b1;
    push(128'haaaa, 128'h1);
    push(128'hbbbb, 128'h2);
    got_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    mon_en = 1'b0;
    check_val("bp_no_issue", 128'(got_q.size()), 128'd0);
    check_val("bp_level2", 128'(level), 128'd2);
    out_busy = 1'b0;
    tick();
    check_val("bp_first_valid", 128'(out_valid), 128'd1);
    check_val("bp_first_real", out_real, 128'haaaa);
    tick(); tick(); tick();
    check_val("bp_second_valid", 128'(out_valid), 128'd1);
    check_val("bp_second_real", out_real, 128'hbbbb);
    tick(); tick();

    // Wrap-around: 10 frames, one push every 3 cycles
    got_q.delete();
    max_lvl = 0;
    mon_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      push(128'(16'h5000 + k), 128'(k));
      tick(); tick();
    end
    for (int i = 0; i < 6; i++) tick();
    mon_en = 1'b0;
    check_val("wrap_count", 128'(got_q.size()), 128'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < got_q.size()) check_val($sformatf("wrap_real%0d", k), got_q[k], 128'(16'h5000 + k));
    end
    check_val("wrap_max_level_le2", 128'(max_lvl <= 2), 128'd1);
    check_val("wrap_no_ovf", 128'(overflow), 128'd0);

    // Reset mid-operation discards stored frames
    out_busy = 1'b1;
    push(128'h1111, 128'h0);
    push(128'h2222, 128'h0);
    push(128'h3333, 128'h0);
    check_val("mid_level3", 128'(level), 128'd3);
    do_reset();
    check_val("mid_rst_level", 128'(level), 128'd0);
    out_busy = 1'b0;
    got_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    mon_en = 1'b0;
    check_val("mid_no_valid", 128'(got_q.size()), 128'd0);
    push(128'h7777, 128'h8888);
    tick();
    check_val("mid_next_valid", 128'(out_valid), 128'd1);
    check_val("mid_next_real", out_real, 128'h7777);
    check_val("mid_next_imag", out_imag, 128'h8888);
`ifdef FFT_DIN_FIFO_STATS_EN
    check_val("mid_in_frames", 128'(in_frames), 128'd1);
    check_val("mid_drop_frames", 128'(drop_frames), 128'd0);
`endif
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
